// File: rtl/bcd_scan_display.sv
// Round-robin scanner for a multiplexed common-anode 7-segment display fed by packed BCD; Value is
// latched once per frame (FRAME pulse), outputs are registered on the state edge, no backpressure.
// Leading-zero blanking is enabled with `define BCD_SCAN_LZ_BLANK_EN.
module bcd_scan_display #(
  parameter int DIGITS = 2,
  parameter int T_SCAN = 50000,
  parameter int T_GAP  = 500
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   Value,
  output logic [6:0]            SEG,
  output logic [DIGITS-1:0]     DIG,
  output logic                  FRAME
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int T_MAX = (T_SCAN > T_GAP) ? T_SCAN : T_GAP;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(T_SCAN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((T_GAP > 0) ? T_GAP - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_q, start_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                frame_q, frame_d;
  logic                advance;
  logic                wrap;
  logic [3:0]          nib;
  logic                blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_GAP;
      idx_q   <= IDX_LAST;
      cnt_q   <= '0;
      start_q <= 1'b1;
      val_q   <= '0;
      seg_q   <= 7'h7F;
      dig_q   <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      val_q   <= val_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  // start_q forces the first post-reset cycle to end the gap whatever T_GAP is.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    start_d = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_SHOW: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (T_GAP > 0) begin
            state_d = ST_GAP;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: begin
        if (start_q || (cnt_q == GAP_LAST)) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
          advance = 1'b1;
        end
      end
    endcase
    wrap = advance && (idx_q == IDX_LAST);
    if (advance) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    val_d = wrap ? Value : val_q;
  end

  // Outputs are computed from the next state so they change on the same edge as the state.
  always_comb begin
    nib = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib = val_d[4*k +: 4];
      end
    end
`ifdef BCD_SCAN_LZ_BLANK_EN
    begin : lz_blank
      logic lz_run;
      lz_run = 1'b1;
      blank  = 1'b0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
        lz_run = lz_run && (val_d[4*k +: 4] == 4'd0);
        if (idx_d == IDX_W'(k)) begin
          blank = lz_run;
        end
      end
    end
`else
    blank = 1'b0;
`endif
    frame_d = wrap;
    if (state_d == ST_SHOW) begin
      dig_d = ~(DIGITS'(1) << idx_d);
      seg_d = blank ? 7'h7F : ~decode(nib);
    end else begin
      dig_d = '1;
      seg_d = 7'h7F;
    end
  end

  assign SEG   = seg_q;
  assign DIG   = dig_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench: DIGITS=2, T_SCAN=4 with T_GAP=1 (dut) and T_GAP=0 (dut0); outputs sampled on negedge.
module tb_bcd_scan_display;

`ifdef BCD_SCAN_LZ_BLANK_EN
  localparam logic [6:0] ZERO_HI_SEG = 7'h7F;
`else
  localparam logic [6:0] ZERO_HI_SEG = 7'h40;
`endif

  logic       clk;
  logic       rst, rst0;
  logic [7:0] value, value0;
  logic [6:0] seg, seg0;
  logic [1:0] dig, dig0;
  logic       frame, frame0;
  int         tests;
  int         fails;

  bcd_scan_display #(.DIGITS(2), .T_SCAN(4), .T_GAP(1)) dut (
    .CLK(clk), .RST(rst), .Value(value), .SEG(seg), .DIG(dig), .FRAME(frame)
  );

  bcd_scan_display #(.DIGITS(2), .T_SCAN(4), .T_GAP(0)) dut0 (
    .CLK(clk), .RST(rst0), .Value(value0), .SEG(seg0), .DIG(dig0), .FRAME(frame0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Check n consecutive cycles of one display slot; FRAME is expected only on the first.
  task automatic expect_run(input bit sel, input int n, input logic [1:0] edig,
                            input logic [6:0] eseg, input logic efirst, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d].dig", tag, i), {6'd0, sel ? dig0 : dig}, {6'd0, edig});
      chk($sformatf("%s[%0d].seg", tag, i), {1'b0, sel ? seg0 : seg}, {1'b0, eseg});
      chk($sformatf("%s[%0d].frame", tag, i), {7'd0, sel ? frame0 : frame},
          {7'd0, (i == 0) ? efirst : 1'b0});
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    rst0   = 1'b1;
    value  = 8'h23;
    value0 = 8'h07;
    repeat (2) @(negedge clk);
    chk("rst.dig", {6'd0, dig}, 8'h03);
    chk("rst.seg", {1'b0, seg}, 8'h7F);
    chk("rst.frame", {7'd0, frame}, 8'h00);
    chk("rst0.dig", {6'd0, dig0}, 8'h03);
    chk("rst0.seg", {1'b0, seg0}, 8'h7F);

    // Frame "23", with Value switching to 19 halfway through digit 1
    rst = 1'b0;
    expect_run(0, 4, 2'b10, 7'h30, 1'b1, "f23_d0");
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "f23_gap0");
    expect_run(0, 2, 2'b01, 7'h24, 1'b0, "f23_d1a");
    value = 8'h19;
    expect_run(0, 2, 2'b01, 7'h24, 1'b0, "f23_d1b");
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "f23_gap1");

    // Frame "19", Value changes to A5 during the frame
    expect_run(0, 4, 2'b10, 7'h10, 1'b1, "f19_d0");
    value = 8'hA5;
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "f19_gap0");
    expect_run(0, 4, 2'b01, 7'h79, 1'b0, "f19_d1");
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "f19_gap1");

    // Frame "A5": invalid nibble shows a dash
    expect_run(0, 4, 2'b10, 7'h12, 1'b1, "fa5_d0");
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "fa5_gap0");
    expect_run(0, 4, 2'b01, 7'h3F, 1'b0, "fa5_d1");
    value = 8'h05;
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "fa5_gap1");

    // Frame "05": leading zero blanked only with the blanking build
    expect_run(0, 4, 2'b10, 7'h12, 1'b1, "f05_d0");
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "f05_gap0");
    expect_run(0, 4, 2'b01, ZERO_HI_SEG, 1'b0, "f05_d1");
    value = 8'h00;
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "f05_gap1");

    // Frame "00": digit 0 is never blanked
    expect_run(0, 4, 2'b10, 7'h40, 1'b1, "f00_d0");
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "f00_gap0");
    expect_run(0, 2, 2'b01, ZERO_HI_SEG, 1'b0, "f00_d1");

    // One-cycle reset while digit 1 is lit
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.dig", {6'd0, dig}, 8'h03);
    chk("rst_mid.seg", {1'b0, seg}, 8'h7F);
    chk("rst_mid.frame", {7'd0, frame}, 8'h00);
    rst   = 1'b0;
    value = 8'h23;
    expect_run(0, 4, 2'b10, 7'h30, 1'b1, "restart_d0");
    expect_run(0, 1, 2'b11, 7'h7F, 1'b0, "restart_gap0");
    expect_run(0, 4, 2'b01, 7'h24, 1'b0, "restart_d1");

    // No gap: digits back to back, frame period 8
    rst0 = 1'b0;
    expect_run(1, 4, 2'b10, 7'h78, 1'b1, "g0_d0");
    expect_run(1, 4, 2'b01, ZERO_HI_SEG, 1'b0, "g0_d1");
    expect_run(1, 4, 2'b10, 7'h78, 1'b1, "g0_d0b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
